// File: rtl/snake_matrix_scan.sv
// Multiplexed LED matrix scanner with double-buffered frame memory.
// Rows are scanned one per row period; each period starts with a blanking
// interval, and the column on-time is scaled by a 4-bit brightness value.
module snake_matrix_scan #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 16,
    parameter int unsigned CLK_DIV    = 6250,
    parameter int unsigned BLANK      = 64,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic            MCLK,
    input  logic            RST_N,
    input  logic            WR_EN,
    input  logic [3:0]      WR_ROW,
    input  logic [COLS-1:0] WR_DATA,
    input  logic            SWAP,
    input  logic [3:0]      BRIGHT,
    output logic [ROWS-1:0] MATRIX_ROW,
    output logic [COLS-1:0] MATRIX_COL,
    output logic            FRAME_START,
    output logic            SWAP_PENDING,
    output logic            SWAP_DONE
);

    localparam int unsigned TW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned CW  = TW + 5;
    localparam logic        OFF = (ACTIVE_LOW != 0);

    logic [TW-1:0]   tick;
    logic [TW-1:0]   tick_nxt;
    logic [RW-1:0]   row;
    logic [RW-1:0]   row_nxt;
    logic            started;
    logic            sel;
    logic [3:0]      bright_q;
    logic [COLS-1:0] buf0 [ROWS];
    logic [COLS-1:0] buf1 [ROWS];

    logic            boundary_c;
    logic            swap_now_c;
    logic            wr_ok_c;
    logic [3:0]      bright_use_c;
    logic            unblank_c;
    logic [CW-1:0]   lhs_c;
    logic [CW-1:0]   rhs_c;
    logic [COLS-1:0] front_row_c;
    logic [ROWS-1:0] row_on_c;
    logic [COLS-1:0] col_on_c;

    // Next tick/row; counters hold at zero for the first cycle after reset.
    always_comb begin
        tick_nxt = tick;
        row_nxt  = row;
        if (started) begin
            if (tick == TW'(CLK_DIV - 1)) begin
                tick_nxt = '0;
                row_nxt  = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
            end else begin
                tick_nxt = tick + TW'(1);
            end
        end
    end

    // Frame-boundary, swap and write qualification.
    always_comb begin
        boundary_c = started && (tick == TW'(CLK_DIV - 1)) && (row == RW'(ROWS - 1));
        swap_now_c = boundary_c && SWAP_PENDING;
        wr_ok_c    = WR_EN && (32'(WR_ROW) < ROWS);
    end

    // Output levels for the upcoming cycle, so registered outputs match its row/tick.
    always_comb begin
        bright_use_c = (tick == TW'(BLANK)) ? BRIGHT : bright_q;
        unblank_c    = (tick_nxt >= TW'(BLANK));
        lhs_c        = (CW'(tick_nxt) - CW'(BLANK)) << 4;
        rhs_c        = CW'(CLK_DIV - BLANK) * (CW'(bright_use_c) + CW'(1));
        front_row_c  = sel ? buf1[row_nxt] : buf0[row_nxt];
        row_on_c     = '0;
        col_on_c     = '0;
        if (unblank_c) begin
            row_on_c = ROWS'(1) << row_nxt;
            if (lhs_c < rhs_c) begin
                col_on_c = front_row_c;
            end
        end
    end

    // Counters, swap control, brightness latch and registered outputs.
    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            tick         <= '0;
            row          <= '0;
            started      <= 1'b0;
            sel          <= 1'b0;
            bright_q     <= '0;
            SWAP_PENDING <= 1'b0;
            SWAP_DONE    <= 1'b0;
            FRAME_START  <= 1'b0;
            MATRIX_ROW   <= {ROWS{OFF}};
            MATRIX_COL   <= {COLS{OFF}};
        end else begin
            tick         <= tick_nxt;
            row          <= row_nxt;
            started      <= 1'b1;
            sel          <= sel ^ swap_now_c;
            if (started && (tick == TW'(BLANK))) begin
                bright_q <= BRIGHT;
            end
            SWAP_PENDING <= swap_now_c ? 1'b0 : (SWAP_PENDING | SWAP);
            SWAP_DONE    <= swap_now_c;
            FRAME_START  <= (tick_nxt == '0) && (row_nxt == '0);
            MATRIX_ROW   <= row_on_c ^ {ROWS{OFF}};
            MATRIX_COL   <= col_on_c ^ {COLS{OFF}};
        end
    end

    // Frame buffers; writes always target the buffer not currently displayed.
    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(ROWS); i++) begin
                buf0[i] <= '0;
                buf1[i] <= '0;
            end
        end else if (wr_ok_c) begin
            if (sel) begin
                buf0[RW'(WR_ROW)] <= WR_DATA;
            end else begin
                buf1[RW'(WR_ROW)] <= WR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_snake_matrix_scan.sv
// Scoreboard bench for snake_matrix_scan (ROWS=4, COLS=8, CLK_DIV=20, BLANK=4).
module tb_snake_matrix_scan;

    localparam int NR = 4;
    localparam int NP = 20;
    localparam int NB = 4;
    localparam int FRAME = NR * NP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_row = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic       swap = 1'b0;
    logic [3:0] bright = 4'd15;
    logic [3:0] matrix_row;
    logic [7:0] matrix_col;
    logic       frame_start;
    logic       swap_pending;
    logic       swap_done;

    typedef struct packed {
        logic [3:0] row;
        logic [7:0] col;
        logic       fs;
        logic       pend;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: position derived from a running cycle count
    bit       running = 0;
    int       t = 0;
    bit [7:0] front [NR];
    bit [7:0] back [NR];
    bit       pend = 0;
    int       bhold = 0;

    snake_matrix_scan #(
        .ROWS(4), .COLS(8), .CLK_DIV(20), .BLANK(4), .ACTIVE_LOW(1)
    ) dut (
        .MCLK(clk), .RST_N(rst_n), .WR_EN(wr_en), .WR_ROW(wr_row),
        .WR_DATA(wr_data), .SWAP(swap), .BRIGHT(bright),
        .MATRIX_ROW(matrix_row), .MATRIX_COL(matrix_col),
        .FRAME_START(frame_start), .SWAP_PENDING(swap_pending),
        .SWAP_DONE(swap_done)
    );

    always #5 clk = ~clk;

    // Apply one clock edge to the model and queue the expected outputs.
    task automatic model_edge();
        exp_t    e;
        bit      boundary;
        bit      done;
        bit [7:0] tmp;
        int      tk;
        int      r;
        if (!rst_n) begin
            running = 0;
            t = 0;
            pend = 0;
            bhold = 0;
            for (int i = 0; i < NR; i++) begin
                front[i] = 8'h00;
                back[i] = 8'h00;
            end
            e = '{row: 4'hF, col: 8'hFF, fs: 1'b0, pend: 1'b0, done: 1'b0};
        end else begin
            boundary = running && (t % FRAME == FRAME - 1);
            done = boundary && pend;
            if (wr_en && wr_row < NR) back[wr_row] = wr_data;
            if (done) begin
                for (int i = 0; i < NR; i++) begin
                    tmp = front[i];
                    front[i] = back[i];
                    back[i] = tmp;
                end
                pend = 0;
            end else if (swap) begin
                pend = 1;
            end
            if (running && (t % NP == NB)) bhold = bright;
            if (running) t++;
            else begin
                running = 1;
                t = 0;
            end
            tk = t % NP;
            r = (t / NP) % NR;
            e.row = 4'hF;
            e.col = 8'hFF;
            if (tk >= NB) begin
                e.row = ~(4'(1) << r);
                if ((tk - NB) * 16 < (NP - NB) * (((tk == NB) ? 0 : bhold) + 1))
                    e.col = ~front[r];
            end
            e.fs = (t % FRAME == 0);
            e.pend = pend;
            e.done = done;
        end
        q.push_back(e);
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic pulse_swap();
        swap = 1'b1;
        tick_cycle();
        swap = 1'b0;
    endtask

    task automatic write_row(input logic [3:0] r, input logic [7:0] d);
        wr_en = 1'b1;
        wr_row = r;
        wr_data = d;
        tick_cycle();
        wr_en = 1'b0;
    endtask

    // Advance until the current cycle is the frame-boundary cycle.
    task automatic to_boundary();
        for (int i = 0; i < FRAME + 1; i++) begin
            if (running && (t % FRAME == FRAME - 1)) break;
            tick_cycle();
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{row: matrix_row, col: matrix_col, fs: frame_start,
                  pend: swap_pending, done: swap_done};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got row=%h col=%h fs=%b pend=%b done=%b expected row=%h col=%h fs=%b pend=%b done=%b",
                         $time, a.row, a.col, a.fs, a.pend, a.done,
                         e.row, e.col, e.fs, e.pend, e.done);
            end
        end
    end

    initial begin
        // Reset, then free-run with no writes
        run(3);
        rst_n = 1'b1;
        run(2 * FRAME + 10);

        // Write to back buffer only, then swap it in
        write_row(4'd2, 8'hA5);
        run(FRAME);
        pulse_swap();
        run(2 * FRAME);

        // Brightness: full then half on row 0
        bright = 4'd15;
        write_row(4'd0, 8'hFF);
        pulse_swap();
        run(2 * FRAME);
        bright = 4'd7;
        run(FRAME);
        bright = 4'd0;
        run(FRAME);

        // Two swap requests in one frame, then a swap in the boundary cycle
        bright = 4'd15;
        run(10);
        pulse_swap();
        run(15);
        pulse_swap();
        run(2 * FRAME);
        to_boundary();
        write_row(4'd1, 8'h3C);
        to_boundary();
        pulse_swap();
        run(2 * FRAME + 5);

        // Out-of-range write, then reset with a swap pending
        write_row(4'd5, 8'hFF);
        pulse_swap();
        run(FRAME + 30);
        pulse_swap();
        run(3);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(FRAME + 5);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            wr_en = ($urandom_range(0, 3) == 0);
            wr_row = 4'($urandom_range(0, 5));
            wr_data = 8'($urandom);
            swap = ($urandom_range(0, 59) == 0);
            bright = 4'($urandom);
            rst_n = ($urandom_range(0, 699) != 0);
            tick_cycle();
        end
        rst_n = 1'b1;
        swap = 1'b0;
        wr_en = 1'b0;
        run(5);

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain leftover=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
